// File: rtl/addr_burst_gen.sv
// rtl/addr_burst_gen.sv - burst address generator with valid/ready output and CLA next-address adder
// Optional build macro ZILLA_AGU_WRAP_DETECT_EN adds the sticky wrap_err output.

module cla_adder_12bit (
  input  logic [11:0] ain,
  input  logic [11:0] bin,
  input  logic        cin,
  output logic [11:0] sum
);

  // Carry out of bit 11 is discarded, so bit-11 generate is never formed.
  logic [10:0] g;
  logic [11:0] p;
  logic [11:0] c;
  logic        gg0, pg0, gg1, pg1, c4, c8;

  assign g = ain[10:0] & bin[10:0];
  assign p = ain ^ bin;

  assign gg0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg0 = &p[3:0];
  assign gg1 = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
  assign pg1 = &p[7:4];

  assign c4 = gg0 | (pg0 & cin);
  assign c8 = gg1 | (pg1 & gg0) | (pg1 & pg0 & cin);

  always_comb begin
    logic cg;
    int   b;
    c  = '0;
    cg = 1'b0;
    b  = 0;
    for (int grp = 0; grp < 3; grp++) begin
      b      = grp * 4;
      cg     = (grp == 0) ? cin : (grp == 1) ? c4 : c8;
      c[b]   = cg;
      c[b+1] = g[b] | (p[b] & cg);
      c[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & cg);
      c[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
             | (p[b+2] & p[b+1] & p[b] & cg);
    end
  end

  assign sum = p ^ c;

endmodule

module addr_burst_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [11:0]      base_addr,
  input  logic [11:0]      stride,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic [11:0]      addr_out,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic             addr_last,
  output logic             busy,
`ifdef ZILLA_AGU_WRAP_DETECT_EN
  output logic             wrap_err,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      stride_q;
  logic [11:0]      sum;
  logic             accept, step, advance, last_beat;

  assign accept    = (state == IDLE) && start;
  assign last_beat = (cnt == CNT_W'(1));
  // Abort wins over a coincident handshake: the burst does not step.
  assign step      = (state == RUN) && addr_ready && !abort;
  assign advance   = step && !last_beat;

  cla_adder_12bit u_add (
    .ain (addr_out),
    .bin (stride_q),
    .cin (1'b0),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (len != '0) ? RUN : DONE;
      RUN: begin
        if (abort)                      state_nx = IDLE;
        else if (step && last_beat)     state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    addr_valid = (state == RUN);
    addr_last  = (state == RUN) && last_beat;
    busy       = (state != IDLE);
    done       = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_out <= '0;
      cnt      <= '0;
      stride_q <= '0;
    end else if (accept) begin
      addr_out <= base_addr;
      cnt      <= len;
      stride_q <= stride;
    end else if (advance) begin
      addr_out <= sum;
      cnt      <= cnt - CNT_W'(1);
    end
  end

`ifdef ZILLA_AGU_WRAP_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst || accept)                                          wrap_err <= 1'b0;
    else if (advance && (sum < addr_out) && (stride_q != '0))   wrap_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_addr_burst_gen.sv
// tb/tb_addr_burst_gen.sv - scoreboard bench for addr_burst_gen
// Checks wrap_err too when built with ZILLA_AGU_WRAP_DETECT_EN.

module tb_addr_burst_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort, addr_ready;
  logic [11:0] base_addr, stride;
  logic [7:0]  len;
  logic [11:0] addr_out;
  logic        addr_valid, addr_last, busy, done;
`ifdef ZILLA_AGU_WRAP_DETECT_EN
  logic        wrap_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int n_hs     = 0;
  int n_done   = 0;
  logic [12:0] sb[$];

  always #5 clk = ~clk;

  addr_burst_gen #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .stride     (stride),
    .len        (len),
    .abort      (abort),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_last  (addr_last),
    .busy       (busy),
`ifdef ZILLA_AGU_WRAP_DETECT_EN
    .wrap_err   (wrap_err),
`endif
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor pops the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (!rst && addr_valid && addr_ready && !abort) begin
      n_hs++;
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'(addr_out), 32'hDEAD);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        check("beat_addr", 32'(addr_out), 32'(e[11:0]));
        check("beat_last", 32'(addr_last), 32'(e[12]));
      end
    end
    if (!rst && done) n_done++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [11:0] b, input logic [11:0] s, input logic [7:0] l);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < int'(l); i++) begin
      sb.push_back({(i == int'(l) - 1), a});
      a = a + s;
    end
    base_addr = b; stride = s; len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int hs0, dn0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    base_addr = '0; stride = '0; len = '0;
    tick(); tick();
    check("rst_addr_out", 32'(addr_out), 32'h0);
    check("rst_valid", 32'(addr_valid), 32'h0);
    check("rst_last", 32'(addr_last), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
`ifdef ZILLA_AGU_WRAP_DETECT_EN
    check("rst_wrap_err", 32'(wrap_err), 32'h0);
`endif
    rst = 1'b0;
    tick();

    // Basic 3-beat burst, full throughput
    dn0 = n_done;
    start_burst(12'h100, 12'd4, 8'd3);
    check("t1_n1_valid", 32'(addr_valid), 32'h1);
    check("t1_n1_addr", 32'(addr_out), 32'h100);
    check("t1_n1_last", 32'(addr_last), 32'h0);
    check("t1_n1_busy", 32'(busy), 32'h1);
    tick();
    check("t1_n2_addr", 32'(addr_out), 32'h104);
    tick();
    check("t1_n3_addr", 32'(addr_out), 32'h108);
    check("t1_n3_last", 32'(addr_last), 32'h1);
    tick();
    check("t1_n4_done", 32'(done), 32'h1);
    check("t1_n4_valid", 32'(addr_valid), 32'h0);
    check("t1_n4_busy", 32'(busy), 32'h1);
    tick();
    check("t1_n5_done", 32'(done), 32'h0);
    check("t1_n5_busy", 32'(busy), 32'h0);
    check("t1_done_count", 32'(n_done - dn0), 32'd1);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure while 0x104 is shown
    hs0 = n_hs;
    start_burst(12'h100, 12'd4, 8'd3);
    tick();
    addr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t2_hold_addr", 32'(addr_out), 32'h104);
      check("t2_hold_valid", 32'(addr_valid), 32'h1);
      check("t2_hold_last", 32'(addr_last), 32'h0);
    end
    addr_ready = 1'b1;
    tick();
    check("t2_last_addr", 32'(addr_out), 32'h108);
    check("t2_last_flag", 32'(addr_last), 32'h1);
    wait_done();
    tick();
    check("t2_handshakes", 32'(n_hs - hs0), 32'd3);

    // Wrap through 0xFFF
    start_burst(12'hFF8, 12'd8, 8'd3);
    tick();
    check("t3_wrap_addr", 32'(addr_out), 32'h000);
    wait_done();
    tick();
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
`ifdef ZILLA_AGU_WRAP_DETECT_EN
    check("t3_wrap_err_idle", 32'(wrap_err), 32'h1);
`endif

    // Zero-length burst
    start_burst(12'h050, 12'd1, 8'd0);
`ifdef ZILLA_AGU_WRAP_DETECT_EN
    check("t4_wrap_err_clr", 32'(wrap_err), 32'h0);
`endif
    check("t4_n1_done", 32'(done), 32'h1);
    check("t4_n1_valid", 32'(addr_valid), 32'h0);
    tick();
    check("t4_n2_done", 32'(done), 32'h0);
    check("t4_n2_busy", 32'(busy), 32'h0);

    // Abort after 4th handshake, then a fresh burst
    hs0 = n_hs; dn0 = n_done;
    start_burst(12'h010, 12'd1, 8'd10);
    tick(); tick(); tick(); tick();
    check("t5_pre_abort_addr", 32'(addr_out), 32'h014);
    addr_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; addr_ready = 1'b1;
    check("t5_abort_valid", 32'(addr_valid), 32'h0);
    check("t5_abort_busy", 32'(busy), 32'h0);
    tick();
    check("t5_abort_no_done", 32'(n_done - dn0), 32'd0);
    check("t5_abort_hs", 32'(n_hs - hs0), 32'd4);
    sb.delete();
    start_burst(12'h300, 12'd2, 8'd2);
    check("t5_restart_addr", 32'(addr_out), 32'h300);
    wait_done();
    tick();

    // Mid-burst reset
    start_burst(12'h400, 12'd1, 8'd5);
    tick();
    addr_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; addr_ready = 1'b1;
    check("t5r_rst_addr", 32'(addr_out), 32'h0);
    check("t5r_rst_valid", 32'(addr_valid), 32'h0);
    check("t5r_rst_busy", 32'(busy), 32'h0);
    sb.delete();
    tick();

    // Start while busy is ignored
    dn0 = n_done;
    start_burst(12'h100, 12'd4, 8'd3);
    base_addr = 12'h200; stride = 12'd1; len = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_addr_unchanged", 32'(addr_out), 32'h104);
    wait_done();
    tick(); tick();
    check("t6_done_once", 32'(n_done - dn0), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    check("t6_idle", 32'(busy), 32'h0);

    // Zero stride repeats the base address
    start_burst(12'h0AB, 12'd0, 8'd3);
    wait_done();
    tick();
    check("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
